// File: rtl/axi_mem_slave.sv
// axi_mem_slave
//   Parametrised AXI-style memory slave on a shared-address bus. A single
//   address channel (awrite selects direction) feeds either a write burst on
//   the W channel or a read burst on the R channel. There is no write-response
//   channel. Supports FIXED / INCR / WRAP bursts, narrow transfers, byte
//   strobes and one-beat-per-cycle read bursts.
//
//   Optional feature: define AXI_MEM_SLAVE_CHECK_EN to build the sticky
//   protocol checker driving err. When it is undefined, err is tied low.
//
// Parameters
//   ID_W   : width of aid / wid / rid
//   ADDR_W : byte address width
//   DATA_W : data width in bits (power of 2, 32..1024)
//   LEN_W  : burst length field width (beats = alen + 1)
//   DEPTH  : memory depth in DATA_W words (power of 2)
//
// Ports
//   clk, reset               : clock (rising edge), async active-high reset
//   aid/aaddr/avalid/awrite  : address channel; aready is high only in IDLE
//   alen/asize/aburst        : burst length, log2 beat size, burst type
//   wid/wdata/wstrb/wlast    : write data channel, wvalid/wready handshake
//   rid/rdata/rlast/rvalid   : registered read data channel, rready handshake
//   err                      : sticky protocol error
module axi_mem_slave #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     aid,
  input  logic [ADDR_W-1:0]   aaddr,
  input  logic                avalid,
  input  logic                awrite,
  input  logic [LEN_W-1:0]    alen,
  input  logic [1:0]          asize,
  input  logic [1:0]          aburst,
  output logic                aready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic                err
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LOG_BYTES = $clog2(STRB_W);
  localparam int LOG_DEPTH = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [1:0]          size_q;
  logic [1:0]          burst_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [1:0]          asize_c;
  logic                w_hs;

  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic wrap_legal(input logic [LEN_W-1:0] len);
    logic [31:0] l;
    l = 32'(len);
    return (l == 32'd1) || (l == 32'd3) || (l == 32'd7) || (l == 32'd15);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        sz,
    input logic [LEN_W-1:0]  len,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] bnd;
    logic [ADDR_W-1:0] nxt;
    inc = ADDR_W'(1) << sz;
    bnd = inc * (ADDR_W'(len) + ADDR_W'(1));
    if (burst == 2'b00) begin
      nxt = a;
    end else if (burst == 2'b10 && wrap_legal(len)) begin
      // Keep the bits above the wrap window, advance within it.
      nxt = (a & ~(bnd - ADDR_W'(1))) | ((a + inc) & (bnd - ADDR_W'(1)));
    end else begin
      // INCR, reserved, and WRAP with an illegal length.
      nxt = (a & ~(inc - ADDR_W'(1))) + inc;
    end
    return nxt;
  endfunction

  function automatic logic [LOG_DEPTH-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[LOG_BYTES +: LOG_DEPTH];
  endfunction

  // Beat size can never exceed the bus width.
  always_comb begin
    asize_c = asize;
    if ({30'd0, asize} > 32'(LOG_BYTES)) asize_c = 2'(LOG_BYTES);
  end

  always_comb begin
    addr_d = next_addr(addr_q, size_q, len_q, burst_q);
  end

  assign w_hs   = wvalid && (state_q == WR);
  assign aready = (state_q == IDLE);
  assign wready = (state_q == WR);
  assign rid    = id_q;
  assign rdata  = rdata_q;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;

`ifdef AXI_MEM_SLAVE_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_chk;
  assign err        = 1'b0;
  assign unused_chk = ^{wid, wlast};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
`ifdef AXI_MEM_SLAVE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (avalid) begin
            id_q    <= aid;
            addr_q  <= aaddr;
            len_q   <= alen;
            size_q  <= asize_c;
            burst_q <= aburst;
            cnt_q   <= alen;
            if (awrite) begin
              state_q <= WR;
            end else begin
              // First read beat is fetched on the handshake edge itself.
              state_q  <= RD;
              rdata_q  <= mem[widx(aaddr)];
              rvalid_q <= 1'b1;
              rlast_q  <= (alen == '0);
            end
`ifdef AXI_MEM_SLAVE_CHECK_EN
            if (aburst == 2'b11 || (aburst == 2'b10 && !wrap_legal(alen))) err_q <= 1'b1;
`endif
          end
        end
        WR: begin
          if (wvalid) begin
            addr_q <= addr_d;
            if (cnt_q == '0) state_q <= IDLE;
            else             cnt_q   <= cnt_q - LEN_W'(1);
`ifdef AXI_MEM_SLAVE_CHECK_EN
            if ((wlast != (cnt_q == '0)) || (wid != id_q)) err_q <= 1'b1;
`endif
          end
        end
        RD: begin
          if (rready) begin
            if (cnt_q == '0) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              // Prefetch the following beat on the accepting edge.
              cnt_q   <= cnt_q - LEN_W'(1);
              addr_q  <= addr_d;
              rdata_q <= mem[widx(addr_d)];
              rlast_q <= (cnt_q == LEN_W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx(addr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

  localparam int ID_W   = 6;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              reset;
  logic [ID_W-1:0]   aid;
  logic [ADDR_W-1:0] aaddr;
  logic              avalid;
  logic              awrite;
  logic [LEN_W-1:0]  alen;
  logic [1:0]        asize;
  logic [1:0]        aburst;
  logic              aready;
  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              err;

  axi_mem_slave #(
    .ID_W  (ID_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .aid   (aid),
    .aaddr (aaddr),
    .avalid(avalid),
    .awrite(awrite),
    .alen  (alen),
    .asize (asize),
    .aburst(aburst),
    .aready(aready),
    .wid   (wid),
    .wdata (wdata),
    .wstrb (wstrb),
    .wlast (wlast),
    .wvalid(wvalid),
    .wready(wready),
    .rid   (rid),
    .rdata (rdata),
    .rlast (rlast),
    .rvalid(rvalid),
    .rready(rready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference memory: one 64-bit word per index.
  logic [63:0] mm [DEPTH];
  bit          err_exp   = 1'b0;
  bit          rand_strb = 1'b0;
  logic [63:0] wq_data [$];
  logic [7:0]  wq_strb [$];
  logic [63:0] rd_seen [$];

  // Byte address of beat i, computed from the window/offset view of a burst.
  function automatic logic [31:0] m_addr(input logic [31:0] start, input int unsigned size,
                                         input int unsigned len, input int unsigned burst,
                                         input int unsigned i);
    logic [63:0] inc, b, base, off, s;
    inc = 64'd1 << size;
    s   = 64'(start);
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      b    = 64'(len + 1) * inc;
      base = s - (s % b);
      off  = (s - base + 64'(i) * inc) % b;
      return 32'(base + off);
    end
    if (i == 0) return start;
    return 32'((s - (s % inc)) + 64'(i) * inc);
  endfunction

  function automatic logic [9:0] m_word(input logic [31:0] a);
    return a[12:3];
  endfunction

  task automatic do_addr(input logic [5:0] id, input logic [31:0] addr, input bit wr,
                         input int unsigned len, input int unsigned size, input int unsigned burst);
    int unsigned n;
    aid = id; aaddr = addr; awrite = wr; alen = 4'(len); asize = 2'(size); aburst = 2'(burst);
    avalid = 1'b1;
    n = 0;
    while (aready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_total++;
      $display("FAIL aready_timeout: aready=%b required 1 within 20 cycles", aready);
    end
    @(negedge clk);
    avalid = 1'b0;
`ifdef AXI_MEM_SLAVE_CHECK_EN
    if (burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))) err_exp = 1'b1;
`endif
  endtask

  task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input int unsigned len,
                             input int unsigned size, input int unsigned burst, input int unsigned gap_pct);
    logic [63:0] d;
    logic [7:0]  s;
    logic [9:0]  w;
    do_addr(id, addr, 1'b1, len, size, burst);
    for (int unsigned i = 0; i <= len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      if (wq_data.size() != 0) d = wq_data.pop_front();
      else                     d = {$urandom, $urandom};
      if (wq_strb.size() != 0) s = wq_strb.pop_front();
      else if (rand_strb)      s = 8'($urandom);
      else                     s = 8'hFF;
      wid = id; wdata = d; wstrb = s; wlast = (i == len); wvalid = 1'b1;
      n_total++;
      if (wready !== 1'b1) $display("FAIL wready: beat %0d wready=%b required 1", i, wready);
      else n_pass++;
      @(negedge clk);
      w = m_word(m_addr(addr, size, len, burst, i));
      for (int b = 0; b < 8; b++) if (s[b]) mm[w][b*8 +: 8] = d[b*8 +: 8];
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    n_total++;
    if (aready !== 1'b1 || wready !== 1'b0)
      $display("FAIL wr_done: aready=%b wready=%b required 1/0", aready, wready);
    else n_pass++;
  endtask

  task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input int unsigned len,
                            input int unsigned size, input int unsigned burst,
                            input int unsigned rdy_pct, input int unsigned hold);
    int unsigned i, cyc;
    bit          rr, have_prev;
    logic [63:0] exp_d;
    logic [70:0] prev;
    do_addr(id, addr, 1'b0, len, size, burst);
    rd_seen.delete();
    i = 0; cyc = 0; have_prev = 1'b0; prev = '0;
    while (i <= len && cyc < 200) begin
      rr = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      rready = rr;
      n_total++;
      if (rvalid !== 1'b1) $display("FAIL rvalid: beat %0d rvalid=%b required 1", i, rvalid);
      else n_pass++;
      if (have_prev) begin
        n_total++;
        if ({rdata, rlast, rid} !== prev)
          $display("FAIL rd_hold: rdata/rlast/rid=%h required %h", {rdata, rlast, rid}, prev);
        else n_pass++;
      end
      if (rr) begin
        exp_d = mm[m_word(m_addr(addr, size, len, burst, i))];
        n_total++;
        if (rdata !== exp_d || rlast !== (i == len) || rid !== id)
          $display("FAIL rdata: beat %0d got data=%h last=%b id=%h required data=%h last=%b id=%h",
                   i, rdata, rlast, rid, exp_d, (i == len), id);
        else n_pass++;
        rd_seen.push_back(rdata);
        i++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev = {rdata, rlast, rid};
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (i <= len) begin
      n_total++;
      $display("FAIL rd_timeout: %0d beats received required %0d", i, len + 1);
    end
    n_total++;
    if (rvalid !== 1'b0 || aready !== 1'b1)
      $display("FAIL rd_end: rvalid=%b aready=%b required 0/1", rvalid, aready);
    else n_pass++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; avalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    aid = '0; aaddr = '0; avalid = 1'b0; awrite = 1'b0; alen = '0; asize = '0; aburst = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (aready !== 1'b1 || wready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 ||
        rdata !== 64'd0 || rid !== 6'd0 || err !== 1'b0)
      $display("FAIL reset: aready=%b wready=%b rvalid=%b rlast=%b rdata=%h rid=%h err=%b required 1/0/0/0/0/0/0",
               aready, wready, rvalid, rlast, rdata, rid, err);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_memory();
    rand_strb = 1'b0;
    for (int unsigned k = 0; k < DEPTH / 16; k++) write_burst(6'(k), 32'(k * 128), 15, 3, 1, 0);
  endtask

  task automatic test_incr();
    for (int k = 0; k < 4; k++) begin
      wq_data.push_back(64'hA0 + 64'(k));
      wq_strb.push_back(8'hFF);
    end
    write_burst(6'h2A, 32'h100, 3, 3, 1, 0);
    read_burst(6'h2A, 32'h100, 3, 3, 1, 100, 0);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rd_seen.size() != 4 || rd_seen[k] !== 64'hA0 + 64'(k))
        $display("FAIL incr_data: beat %0d got %h required %h", k, rd_seen[k], 64'hA0 + 64'(k));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_q [4];
    exp_q = '{64'hA3, 64'hA0, 64'hA1, 64'hA2};
    read_burst(6'h15, 32'h118, 3, 3, 2, 100, 0);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rd_seen.size() != 4 || rd_seen[k] !== exp_q[k])
        $display("FAIL wrap_order: beat %0d got %h required %h", k, rd_seen[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_strobe();
    wq_data.push_back(64'd0);
    wq_strb.push_back(8'hFF);
    write_burst(6'h01, 32'h200, 0, 3, 1, 0);
    wq_data.push_back(64'h1122334455667788);
    wq_strb.push_back(8'h0F);
    write_burst(6'h01, 32'h200, 0, 3, 1, 0);
    read_burst(6'h01, 32'h200, 0, 3, 1, 100, 0);
    n_total++;
    if (rd_seen.size() != 1 || rd_seen[0] !== 64'h0000000055667788)
      $display("FAIL strobe: got %h required 0000000055667788", rd_seen[0]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    read_burst(6'h33, 32'h100, 1, 3, 1, 100, 3);
    n_total++;
    if (rd_seen.size() != 2 || rd_seen[0] !== 64'hA0 || rd_seen[1] !== 64'hA1)
      $display("FAIL backpressure: got %h %h required a0 a1", rd_seen[0], rd_seen[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned len, size, burst;
    logic [31:0] addr;
    logic [5:0]  id;
    rand_strb = 1'b1;
    for (int unsigned t = 0; t < 60; t++) begin
      len   = $urandom_range(15);
      size  = $urandom_range(3);
      burst = $urandom_range(3);
      addr  = $urandom;
      id    = 6'($urandom);
      if ($urandom_range(1) == 1) write_burst(id, addr, len, size, burst, 30);
      else                        read_burst(id, addr, len, size, burst, 70, 0);
      n_total++;
      if (err !== err_exp) $display("FAIL err_sticky: burst %0d err=%b required %b", t, err, err_exp);
      else n_pass++;
    end
    rand_strb = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d;
    do_addr(6'h07, 32'h300, 1'b1, 7, 3, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      wid = 6'h07; wdata = d; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      @(negedge clk);
      mm[m_word(m_addr(32'h300, 3, 7, 1, i))] = d;
    end
    wdata = {$urandom, $urandom};
    reset = 1'b1;
    #1;
    n_total++;
    if (aready !== 1'b1 || wready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_reset: aready=%b wready=%b rvalid=%b err=%b required 1/0/0/0",
               aready, wready, rvalid, err);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; wvalid = 1'b0;
    err_exp = 1'b0;
    read_burst(6'h08, 32'h300, 7, 3, 1, 100, 0);
  endtask

  task automatic test_err();
`ifdef AXI_MEM_SLAVE_CHECK_EN
    n_total++;
    if (err !== 1'b0) $display("FAIL err_clear: err=%b required 0", err);
    else n_pass++;
    do_addr(6'h09, 32'h400, 1'b1, 1, 3, 1);
    wid = 6'h09; wdata = 64'hE0; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    n_total++;
    if (err !== 1'b1) $display("FAIL err_wlast: err=%b required 1", err);
    else n_pass++;
    wdata = 64'hE1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    mm[m_word(32'h400)] = 64'hE0;
    mm[m_word(32'h408)] = 64'hE1;
    read_burst(6'h09, 32'h400, 1, 3, 1, 100, 0);
    n_total++;
    if (rd_seen.size() != 2 || rd_seen[0] !== 64'hE0 || rd_seen[1] !== 64'hE1)
      $display("FAIL err_data: got %h %h required e0 e1", rd_seen[0], rd_seen[1]);
    else n_pass++;
    apply_reset();
    n_total++;
    if (err !== 1'b0) $display("FAIL err_reset: err=%b required 0", err);
    else n_pass++;
    do_addr(6'h0A, 32'h410, 1'b1, 0, 3, 1);
    wid = 6'h0B; wdata = 64'hE2; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    mm[m_word(32'h410)] = 64'hE2;
    n_total++;
    if (err !== 1'b1) $display("FAIL err_wid: err=%b required 1", err);
    else n_pass++;
    apply_reset();
`else
    write_burst(6'h0C, 32'h420, 0, 3, 3, 0);
    n_total++;
    if (err !== 1'b0) $display("FAIL err_tied: err=%b required 0", err);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_incr();
    test_wrap();
    test_strobe();
    test_backpressure();
    test_random();
    test_reset_mid_burst();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
